// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Five-phase instruction sequencer for a small 16-bit datapath. It fetches
// (P1), reads operands (P2), executes (P3), accesses memory (P4) and writes
// back (P5), then loops to P1, returns to IDLE, or parks in HALT.
//
// Instruction classes decoded from instruction[15:14]:
//   11 ALU class, alu_op = instruction[7:4]
//        0000 ADD  0001 SUB  0010 AND  0011 OR   0100 XOR  0101 CMP
//        0110 MOV  10xx shifts        1100 IN   1101 OUT  1111 HLT
//        0111 / 1110 unassigned (no datapath activity)
//   00 LD, 01 ST
//   10 with [13:11] = 000 LI, 100 B, 111 conditional branch ([10:8] = cond)
//
// Parameters
//   TIMEOUT_W      width of the memory-wait counter; limit = 2^TIMEOUT_W-1
//   MEM_HANDSHAKE  1: wait for mem_ack, 0: every transfer completes at once
//   STEP_EN        1: step starts a single-instruction run, 0: step ignored
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   exec, step             run/stop request, single-instruction request
//   instruction            current IR contents
//   alu_s/z/c/v            ALU flag results, captured on flag_e
//   mem_ack                memory transfer complete (P1/P4 only)
//   phase                  0 idle, 1..5 = P1..P5, 6 halted
//   *_e, genr_w, mem_w     datapath enables (combinational from state)
//   m1_s..m8_s             datapath mux selects
//   alu_instruction        6-bit ALU control code
//   running, halted        status decoded from phase
//   bus_err                sticky memory-timeout flag
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int TIMEOUT_W     = 8,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit STEP_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec,
  input  logic        step,
  input  logic [15:0] instruction,
  input  logic        alu_s,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        mem_ack,
  output logic [2:0]  phase,
  output logic        ir_e,
  output logic        pc_e,
  output logic        ar_e,
  output logic        br_e,
  output logic        dr_e,
  output logic        mdr_e,
  output logic        flag_e,
  output logic        genr_w,
  output logic        mem_e,
  output logic        mem_w,
  output logic        m1_s,
  output logic        m2_s,
  output logic        m3_s,
  output logic        m4_s,
  output logic        m5_s,
  output logic        m6_s,
  output logic        m7_s,
  output logic        m8_s,
  output logic [5:0]  alu_instruction,
  output logic        running,
  output logic        halted,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4,
    S_P5   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  // Last counter value that may still wait; one more miss is the timeout.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state_r, state_n;
  logic [3:0]           flags_r, flags_n;   // {S, Z, C, V}
  logic                 stop_r, stop_n;
  logic                 one_r, one_n;
  logic                 taken_r, taken_n;
  logic                 bus_err_r, bus_err_n;
  logic [TIMEOUT_W-1:0] wait_cnt_r, wait_cnt_n;

  logic [1:0] op_s;
  logic [3:0] alu_op_s;
  logic       is_alu_s, is_ld_s, is_st_s, is_li_s, is_b_s, is_bc_s, is_branch_s;
  logic       is_two_s, is_wr_alu_s, is_mov_s, is_shift_s, is_in_s, is_out_s;
  logic       is_hlt_s, is_mem_s;
  logic       ack_s, take_s;
  logic       unused_s;

  // With the handshake disabled every transfer completes in its first cycle.
  assign ack_s = (MEM_HANDSHAKE != 1'b0) ? mem_ack : 1'b1;

  // Operand register fields and the carry flag are not used by the sequencer.
  assign unused_s = ^{instruction[3:0], flags_r[1]};

  // Instruction class decode.
  always_comb begin
    op_s        = instruction[15:14];
    alu_op_s    = instruction[7:4];
    is_alu_s    = (op_s == 2'b11);
    is_ld_s     = (op_s == 2'b00);
    is_st_s     = (op_s == 2'b01);
    is_li_s     = (op_s == 2'b10) && (instruction[13:11] == 3'b000);
    is_b_s      = (op_s == 2'b10) && (instruction[13:11] == 3'b100);
    is_bc_s     = (op_s == 2'b10) && (instruction[13:11] == 3'b111);
    is_branch_s = is_b_s || is_bc_s;
    is_mem_s    = is_ld_s || is_st_s;
    // ADD..CMP read two registers and update flags.
    is_two_s    = is_alu_s && (alu_op_s <= 4'b0101);
    // ADD..XOR produce a result into DR.
    is_wr_alu_s = is_alu_s && (alu_op_s <= 4'b0100);
    is_mov_s    = is_alu_s && (alu_op_s == 4'b0110);
    is_shift_s  = is_alu_s && (alu_op_s[3:2] == 2'b10);
    is_in_s     = is_alu_s && (alu_op_s == 4'b1100);
    is_out_s    = is_alu_s && (alu_op_s == 4'b1101);
    is_hlt_s    = is_alu_s && (alu_op_s == 4'b1111);
  end

  // ALU control code: ALU class carries its function field, others pass the top bits.
  always_comb begin
    if (is_alu_s) begin
      alu_instruction = {op_s, alu_op_s};
    end else begin
      alu_instruction = instruction[15:10];
    end
  end

  // Branch condition from the registered flags (before any update this cycle).
  always_comb begin
    take_s = 1'b0;
    if (is_b_s) begin
      take_s = 1'b1;
    end else if (is_bc_s) begin
      case (instruction[10:8])
        3'b000:  take_s = flags_r[2];                             // BE
        3'b001:  take_s = flags_r[3] ^ flags_r[0];                // BLT
        3'b010:  take_s = flags_r[2] | (flags_r[3] ^ flags_r[0]); // BLE
        3'b011:  take_s = ~flags_r[2];                            // BNE
        default: take_s = 1'b0;
      endcase
    end else begin
      take_s = 1'b0;
    end
  end

  // State register and sequencer bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      flags_r    <= 4'b0000;
      stop_r     <= 1'b0;
      one_r      <= 1'b0;
      taken_r    <= 1'b0;
      bus_err_r  <= 1'b0;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_n;
      flags_r    <= flags_n;
      stop_r     <= stop_n;
      one_r      <= one_n;
      taken_r    <= taken_n;
      bus_err_r  <= bus_err_n;
      wait_cnt_r <= wait_cnt_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n    = state_r;
    flags_n    = flags_r;
    stop_n     = stop_r;
    one_n      = one_r;
    taken_n    = taken_r;
    bus_err_n  = bus_err_r;
    wait_cnt_n = wait_cnt_r;

    if (running && exec) begin
      stop_n = 1'b1;
    end else begin
      stop_n = stop_r;
    end

    case (state_r)
      S_IDLE: begin
        // exec wins over step, so both together start a free run.
        if (exec) begin
          state_n    = S_P1;
          stop_n     = 1'b0;
          one_n      = 1'b0;
          wait_cnt_n = '0;
        end else if ((STEP_EN != 1'b0) && step) begin
          state_n    = S_P1;
          stop_n     = 1'b0;
          one_n      = 1'b1;
          wait_cnt_n = '0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_P1: begin
        if (ack_s) begin
          state_n = S_P2;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_n   = S_HALT;
          bus_err_n = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
      end
      S_P2: begin
        state_n = S_P3;
      end
      S_P3: begin
        taken_n    = is_branch_s && take_s;
        wait_cnt_n = '0;
        if (flag_e) begin
          flags_n = {alu_s, alu_z, alu_c, alu_v};
        end else begin
          flags_n = flags_r;
        end
        if (is_hlt_s) begin
          state_n = S_HALT;
        end else begin
          state_n = S_P4;
        end
      end
      S_P4: begin
        if (!is_mem_s || ack_s) begin
          state_n = S_P5;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_n   = S_HALT;
          bus_err_n = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
      end
      S_P5: begin
        // An exec seen in P5 counts as a stop request for this boundary.
        if (stop_r || exec || one_r) begin
          state_n = S_IDLE;
          stop_n  = 1'b0;
          one_n   = 1'b0;
        end else begin
          state_n    = S_P1;
          wait_cnt_n = '0;
        end
      end
      S_HALT: begin
        // A timed-out bus can only be recovered by reset.
        if (exec && !bus_err_r) begin
          state_n    = S_P1;
          stop_n     = 1'b0;
          one_n      = 1'b0;
          wait_cnt_n = '0;
        end else begin
          state_n = S_HALT;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Datapath enables and selects for the current phase; anything unlisted stays 0.
  always_comb begin
    ir_e   = 1'b0;
    pc_e   = 1'b0;
    ar_e   = 1'b0;
    br_e   = 1'b0;
    dr_e   = 1'b0;
    mdr_e  = 1'b0;
    flag_e = 1'b0;
    genr_w = 1'b0;
    mem_e  = 1'b0;
    mem_w  = 1'b0;
    m1_s   = 1'b0;
    m2_s   = 1'b0;
    m3_s   = 1'b0;
    m4_s   = 1'b0;
    m5_s   = 1'b0;
    m6_s   = 1'b0;
    m7_s   = 1'b0;
    m8_s   = 1'b0;

    case (state_r)
      S_P1: begin
        mem_e = 1'b1;
        m1_s  = 1'b1;
        ir_e  = ack_s;
        pc_e  = ack_s;
      end
      S_P2: begin
        ar_e = is_two_s || is_out_s || is_st_s;
        br_e = is_two_s || is_shift_s || is_mem_s;
      end
      S_P3: begin
        dr_e   = is_wr_alu_s || is_shift_s || is_mem_s || is_branch_s;
        m2_s   = is_shift_s || is_mem_s || is_branch_s;
        flag_e = is_two_s || is_shift_s;
      end
      S_P4: begin
        mem_e = is_mem_s;
        mem_w = is_st_s;
        m6_s  = is_st_s;
        mdr_e = is_ld_s && ack_s;
      end
      S_P5: begin
        genr_w = is_wr_alu_s || is_mov_s || is_shift_s || is_in_s || is_ld_s || is_li_s;
        m5_s   = is_wr_alu_s || is_mov_s || is_shift_s || is_in_s || is_li_s;
        m8_s   = is_li_s;
        m4_s   = is_in_s;
        m7_s   = is_in_s;
        pc_e   = taken_r;
        m3_s   = taken_r;
      end
      default: begin
        ir_e = 1'b0;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    phase   = state_r;
    running = (state_r >= S_P1) && (state_r <= S_P5);
    halted  = (state_r == S_HALT);
    bus_err = bus_err_r;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed bench: a table of single-step instructions with the expected enable
// pattern for every phase, followed by hand-written multi-cycle sequences
// (free run and stop, branch on flags, delayed store ack and reset mid-wait,
// fetch timeout, step gating, HLT). dut uses TIMEOUT_W=4; dut_ns has step and
// handshake disabled. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  // Enable vector bit positions.
  localparam logic [17:0] IR = 18'h20000, PC = 18'h10000, AR = 18'h08000, BR = 18'h04000;
  localparam logic [17:0] DR = 18'h02000, MDR = 18'h01000, FL = 18'h00800, GW = 18'h00400;
  localparam logic [17:0] ME = 18'h00200, MW = 18'h00100, M1 = 18'h00080, M2 = 18'h00040;
  localparam logic [17:0] M3 = 18'h00020, M4 = 18'h00010, M5 = 18'h00008, M6 = 18'h00004;
  localparam logic [17:0] M7 = 18'h00002, M8 = 18'h00001, NONE = 18'h00000;
  localparam logic [17:0] FETCH = IR | PC | ME | M1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exec = 1'b0, step = 1'b0, mem_ack = 1'b1;
  logic        alu_s = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
  logic [15:0] instruction = 16'h0000;

  logic [2:0] phase, n_phase;
  logic ir_e, pc_e, ar_e, br_e, dr_e, mdr_e, flag_e, genr_w, mem_e, mem_w;
  logic m1_s, m2_s, m3_s, m4_s, m5_s, m6_s, m7_s, m8_s, running, halted, bus_err;
  logic [5:0] alu_instruction;
  logic n_ir_e, n_pc_e, n_ar_e, n_br_e, n_dr_e, n_mdr_e, n_flag_e, n_genr_w, n_mem_e, n_mem_w;
  logic n_m1_s, n_m2_s, n_m3_s, n_m4_s, n_m5_s, n_m6_s, n_m7_s, n_m8_s, n_running, n_halted, n_bus_err;
  logic [5:0] n_alu_instruction;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  control_sequencer #(.TIMEOUT_W(4), .MEM_HANDSHAKE(1'b1), .STEP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .exec(exec), .step(step), .instruction(instruction),
    .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .mem_ack(mem_ack),
    .phase(phase), .ir_e(ir_e), .pc_e(pc_e), .ar_e(ar_e), .br_e(br_e), .dr_e(dr_e),
    .mdr_e(mdr_e), .flag_e(flag_e), .genr_w(genr_w), .mem_e(mem_e), .mem_w(mem_w),
    .m1_s(m1_s), .m2_s(m2_s), .m3_s(m3_s), .m4_s(m4_s), .m5_s(m5_s), .m6_s(m6_s),
    .m7_s(m7_s), .m8_s(m8_s), .alu_instruction(alu_instruction), .running(running),
    .halted(halted), .bus_err(bus_err)
  );

  control_sequencer #(.TIMEOUT_W(4), .MEM_HANDSHAKE(1'b0), .STEP_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .exec(exec), .step(step), .instruction(instruction),
    .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .mem_ack(mem_ack),
    .phase(n_phase), .ir_e(n_ir_e), .pc_e(n_pc_e), .ar_e(n_ar_e), .br_e(n_br_e),
    .dr_e(n_dr_e), .mdr_e(n_mdr_e), .flag_e(n_flag_e), .genr_w(n_genr_w),
    .mem_e(n_mem_e), .mem_w(n_mem_w), .m1_s(n_m1_s), .m2_s(n_m2_s), .m3_s(n_m3_s),
    .m4_s(n_m4_s), .m5_s(n_m5_s), .m6_s(n_m6_s), .m7_s(n_m7_s), .m8_s(n_m8_s),
    .alu_instruction(n_alu_instruction), .running(n_running), .halted(n_halted),
    .bus_err(n_bus_err)
  );

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [5:0]  alu;
    logic [17:0] p2, p3, p4, p5;
  } row_t;

  row_t rows[15];

  function automatic logic [17:0] en_vec();
    return {ir_e, pc_e, ar_e, br_e, dr_e, mdr_e, flag_e, genr_w, mem_e, mem_w,
            m1_s, m2_s, m3_s, m4_s, m5_s, m6_s, m7_s, m8_s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; exec = 1'b0; step = 1'b0; mem_ack = 1'b1;
    alu_s = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a one-instruction run; returns at the P1 sample point.
  task automatic step_instr(input logic [15:0] ins);
    instruction = ins;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  initial begin
    int n;
    logic [17:0] exp_v;

    rows[0]  = '{"ADD", 16'hC800, 6'b110000, AR | BR, DR | FL, NONE, GW | M5};
    rows[1]  = '{"SUB", 16'hC810, 6'b110001, AR | BR, DR | FL, NONE, GW | M5};
    rows[2]  = '{"CMP", 16'hC850, 6'b110101, AR | BR, FL, NONE, NONE};
    rows[3]  = '{"MOV", 16'hC860, 6'b110110, NONE, NONE, NONE, GW | M5};
    rows[4]  = '{"SLL", 16'hC880, 6'b111000, BR, DR | M2 | FL, NONE, GW | M5};
    rows[5]  = '{"IN",  16'hC8C0, 6'b111100, NONE, NONE, NONE, GW | M5 | M4 | M7};
    rows[6]  = '{"OUT", 16'hC8D0, 6'b111101, AR, NONE, NONE, NONE};
    rows[7]  = '{"LD",  16'h0000, 6'b000000, BR, DR | M2, ME | MDR, GW};
    rows[8]  = '{"ST",  16'h4000, 6'b010000, AR | BR, DR | M2, ME | MW | M6, NONE};
    rows[9]  = '{"LI",  16'h8000, 6'b100000, NONE, NONE, NONE, GW | M5 | M8};
    rows[10] = '{"B",   16'hA000, 6'b101000, NONE, DR | M2, NONE, PC | M3};
    rows[11] = '{"BE0", 16'hB800, 6'b101110, NONE, DR | M2, NONE, NONE};
    rows[12] = '{"BNE0", 16'hBB00, 6'b101110, NONE, DR | M2, NONE, PC | M3};
    rows[13] = '{"BLT0", 16'hB900, 6'b101110, NONE, DR | M2, NONE, NONE};
    rows[14] = '{"BC4", 16'hBC00, 6'b101111, NONE, DR | M2, NONE, NONE};

    // Reset state.
    #3;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_enables", 32'(en_vec()), 32'd0);
    chk("rst_status", 32'({running, halted, bus_err}), 32'd0);
    do_reset();

    // Table: each instruction as a single step with mem_ack held high.
    for (int r = 0; r < 15; r++) begin
      do_reset();
      step_instr(rows[r].instr);
      for (int p = 1; p <= 5; p++) begin
        case (p)
          1: exp_v = FETCH;
          2: exp_v = rows[r].p2;
          3: exp_v = rows[r].p3;
          4: exp_v = rows[r].p4;
          default: exp_v = rows[r].p5;
        endcase
        chk($sformatf("%s_phase%0d", rows[r].name, p), 32'(phase), 32'(p));
        chk($sformatf("%s_en_p%0d", rows[r].name, p), 32'(en_vec()), 32'(exp_v));
        if (p == 2) chk($sformatf("%s_aluinst", rows[r].name), 32'(alu_instruction), 32'(rows[r].alu));
        @(negedge clk);
      end
      chk($sformatf("%s_idle_after", rows[r].name), 32'(phase), 32'd0);
    end

    // ADD free run from an exec pulse, then stop with a second pulse.
    do_reset();
    instruction = 16'hC800;
    exec = 1'b1;
    @(negedge clk);
    exec = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      chk($sformatf("run_phase%0d", p), 32'(phase), 32'(p));
      chk($sformatf("run_flag_e_p%0d", p), 32'(flag_e), 32'(p == 3));
      chk($sformatf("run_genr_w_p%0d", p), 32'(genr_w), 32'(p == 5));
      @(negedge clk);
    end
    chk("run_loops_to_p1", 32'(phase), 32'd1);
    chk("run_aluinst", 32'(alu_instruction), 32'b110000);
    exec = 1'b1;
    @(negedge clk);
    exec = 1'b0;
    n = 0;
    while (phase != 3'd0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("stop_idle", 32'(phase), 32'd0);
    chk("stop_cycles", 32'(n), 32'd4);

    // CMP sets Z, BE taken; CMP clears Z, BE not taken.
    do_reset();
    alu_z = 1'b1;
    step_instr(16'hC850);
    repeat (5) @(negedge clk);
    chk("cmpz1_idle", 32'(phase), 32'd0);
    step_instr(16'hB800);
    repeat (4) @(negedge clk);
    chk("be_taken_phase", 32'(phase), 32'd5);
    chk("be_taken_pc_m3", 32'({pc_e, m3_s}), 32'b11);
    repeat (1) @(negedge clk);
    alu_z = 1'b0;
    step_instr(16'hC850);
    repeat (5) @(negedge clk);
    step_instr(16'hB800);
    repeat (4) @(negedge clk);
    chk("be_not_phase", 32'(phase), 32'd5);
    chk("be_not_pc_m3", 32'({pc_e, m3_s}), 32'b00);
    @(negedge clk);

    // ST with ack delayed three cycles in P4.
    do_reset();
    step_instr(16'h4000);
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("st_wait_phase_c%0d", c), 32'(phase), 32'd4);
      chk($sformatf("st_wait_mem_w_c%0d", c), 32'(mem_w), 32'd1);
      if (c == 4) mem_ack = 1'b1;
      @(negedge clk);
    end
    chk("st_p5_phase", 32'(phase), 32'd5);
    chk("st_p5_mem_w", 32'(mem_w), 32'd0);

    // Reset raised in the middle of a P4 wait.
    do_reset();
    step_instr(16'h4000);
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("st2_waiting", 32'({phase, mem_w}), 32'({3'd4, 1'b1}));
    #2 rst = 1'b1;
    #1;
    chk("rstmid_mem_w_mem_e", 32'({mem_w, mem_e}), 32'b00);
    chk("rstmid_phase", 32'(phase), 32'd0);
    chk("rstmid_enables", 32'(en_vec()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;

    // Fetch timeout with TIMEOUT_W=4.
    do_reset();
    instruction = 16'hC800;
    mem_ack = 1'b0;
    exec = 1'b1;
    @(negedge clk);
    exec = 1'b0;
    n = 0;
    while (phase == 3'd1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_wait_cycles", 32'(n), 32'd15);
    chk("tmo_phase", 32'(phase), 32'd6);
    chk("tmo_bus_err_halted", 32'({bus_err, halted}), 32'b11);
    exec = 1'b1;
    @(negedge clk);
    exec = 1'b0;
    @(negedge clk);
    chk("tmo_exec_ignored", 32'({phase, bus_err}), 32'({3'd6, 1'b1}));
    do_reset();
    chk("tmo_cleared", 32'({phase, bus_err}), 32'd0);

    // step honoured only with STEP_EN=1.
    do_reset();
    step_instr(16'hC800);
    chk("step_ns_idle", 32'(n_phase), 32'd0);
    chk("step_p1", 32'(phase), 32'd1);
    repeat (5) @(negedge clk);
    chk("step_one_then_idle", 32'(phase), 32'd0);
    chk("step_ns_still_idle", 32'(n_phase), 32'd0);

    // exec and step together start a free run.
    do_reset();
    exec = 1'b1;
    step = 1'b1;
    @(negedge clk);
    exec = 1'b0;
    step = 1'b0;
    repeat (5) @(negedge clk);
    chk("exec_step_freerun", 32'(phase), 32'd1);

    // HLT halts after P3; exec restarts.
    do_reset();
    instruction = 16'hC0F0;
    exec = 1'b1;
    @(negedge clk);
    exec = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hlt_p3", 32'(phase), 32'd3);
    @(negedge clk);
    chk("hlt_phase", 32'(phase), 32'd6);
    chk("hlt_halted", 32'({halted, running}), 32'b10);
    chk("hlt_enables", 32'(en_vec()), 32'd0);
    exec = 1'b1;
    @(negedge clk);
    exec = 1'b0;
    chk("hlt_restart", 32'({phase, halted}), 32'({3'd1, 1'b0}));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
